// File: rtl/modn_seq_checker.sv
// Mod-N sequence checker: locks onto a 0..N-1 wrapping count stream
// and flags sequence breaks and out-of-range samples.
module modn_seq_checker #(
  parameter int N        = 10,
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_val,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0] expected
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] SYNC     = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;

  localparam logic [WIDTH:0]   N_EXT   = (WIDTH+1)'(N);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    ONE_M   = MW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [1:0]       RESYNC  =
    (LOCK_CNT == 1) ? LOCKED : SYNC;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_d;
  logic [WIDTH-1:0] exp_d;
  logic             err_d;
  logic             wrap_d;

  logic             oor;
  logic             hit;
  logic             is_last;
  logic [WIDTH-1:0] succ;

  // Explicit wrap so a non-power-of-two N never relies on overflow.
  assign oor     = {1'b0, in_val} >= N_EXT;
  assign hit     = in_val == expected;
  assign is_last = in_val == LAST;
  assign succ    = is_last ? '0 : in_val + ONE_W;

  always_comb begin
    state_d = state;
    match_d = match_cnt;
    exp_d   = expected;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (in_valid) begin
      if (oor) begin
        err_d   = 1'b1;
        state_d = UNLOCKED;
        match_d = '0;
      end else begin
        exp_d = succ;
        unique case (1'b1)
          state == LOCKED: begin
            if (hit) begin
              wrap_d = is_last;
            end else begin
              err_d   = 1'b1;
              match_d = ONE_M;
              state_d = RESYNC;
            end
          end
          state == SYNC: begin
            if (hit) begin
              if (match_cnt + ONE_M >= LOCK_M) begin
                match_d = LOCK_M;
                state_d = LOCKED;
              end else begin
                match_d = match_cnt + ONE_M;
              end
            end else begin
              match_d = ONE_M;
            end
          end
          default: begin
            match_d = ONE_M;
            state_d = RESYNC;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= UNLOCKED;
      match_cnt <= '0;
      expected  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      wrap_cnt  <= '0;
    end else if (clr) begin
      state     <= UNLOCKED;
      match_cnt <= '0;
      expected  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      wrap_cnt  <= '0;
    end else begin
      state     <= state_d;
      match_cnt <= match_d;
      expected  <= exp_d;
      locked    <= state_d == LOCKED;
      err       <= err_d;
      if (err_d && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + ONE_C;
      if (wrap_d && wrap_cnt != CNT_MAX)
        wrap_cnt <= wrap_cnt + ONE_C;
    end
  end

endmodule
